// File: rtl/pim_pkg.sv
// Shared definitions for the PIM controller program sequencer: opcodes,
// sequencer state encoding and the per-opcode run-cycle budget.
package pim_pkg;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_MUL   = 6'd2;
  localparam logic [5:0] OP_EAST  = 6'd5;
  localparam logic [5:0] OP_WEST  = 6'd6;
  localparam logic [5:0] OP_SOUTH = 6'd7;
  localparam logic [5:0] OP_NORTH = 6'd8;
  localparam logic [5:0] OP_RADD  = 6'd9;
  localparam logic [5:0] OP_RSUB  = 6'd10;
  localparam logic [5:0] OP_HALT  = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_MEMWAIT, S_DECODE, S_LOAD, S_START, S_RUN, S_DONE
  } seq_state_t;

  // Zero means "not an issuable opcode".
  function automatic logic [15:0] cyc_of(input logic [5:0] op, input int unsigned length);
    int unsigned c;
    c = 0;
    case (op)
      OP_ADD, OP_SUB, OP_RADD, OP_RSUB:       c = 2 * length + 2;
      OP_MUL:                                 c = (length + 1) * (2 * length + 5) + 2;
      OP_EAST, OP_WEST, OP_SOUTH, OP_NORTH:   c = length + 3;
      default:                                c = 0;
    endcase
    return c[15:0];
  endfunction

endpackage

// File: rtl/op_budget_decode.sv
// Combinational opcode classifier: issuable, halt, and run-cycle budget.
module op_budget_decode
  import pim_pkg::*;
#(
  parameter int unsigned LENGTH = 32
) (
  input  logic [5:0]  opcode,
  output logic        legal,
  output logic        halt,
  output logic [15:0] budget
);

  always_comb begin
    budget = cyc_of(opcode, LENGTH);
    halt   = (opcode == OP_HALT);
    legal  = (budget != 16'd0);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetches instructions from a synchronous ROM and issues them to the bit-sliced
// Controller: opcode loaded under controller reset, start pulse, fixed run budget.
module instr_sequencer
  import pim_pkg::*;
#(
  parameter int unsigned LENGTH  = 32,
  parameter int unsigned IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               abort,
  input  logic [IMEM_AW-1:0] start_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               ctrl_reset,
  output logic               ctrl_start,
  output logic [31:0]        ctrl_instruction,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [IMEM_AW-1:0] pc,
  output logic [15:0]        instr_count
);

  seq_state_t  state, nxt;
  logic [31:0] ir;
  logic [15:0] bud, cnt;
  logic        dec_legal, dec_halt;
  logic [15:0] dec_budget;

  op_budget_decode #(.LENGTH(LENGTH)) u_dec (
    .opcode (imem_rdata[31:26]),
    .legal  (dec_legal),
    .halt   (dec_halt),
    .budget (dec_budget)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt        = state;
    ctrl_reset = 1'b0;
    ctrl_start = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (go) nxt = S_FETCH;
      S_FETCH:        nxt = S_MEMWAIT;
      S_MEMWAIT:      nxt = S_DECODE;
      S_DECODE: begin
        if (dec_halt)       nxt = S_DONE;
        else if (dec_legal) nxt = S_LOAD;
        else                nxt = S_FETCH;
      end
      S_LOAD:         nxt = S_START;
      S_START: begin
        ctrl_reset = 1'b1;
        ctrl_start = 1'b1;
        nxt        = S_RUN;
      end
      S_RUN: begin
        ctrl_reset = 1'b1;
        if (cnt == 16'd0) nxt = S_FETCH;
      end
      default:        nxt = S_IDLE;
    endcase
    // abort overrides everything, including a simultaneous go
    if (abort) nxt = S_IDLE;
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  // Datapath freezes on abort so pc and instr_count keep their values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc               <= '0;
      imem_addr        <= '0;
      ir               <= '0;
      bud              <= '0;
      cnt              <= '0;
      ctrl_instruction <= '0;
      illegal          <= 1'b0;
      instr_count      <= '0;
    end else if (!abort) begin
      case (state)
        S_IDLE, S_DONE: if (go) begin
          pc          <= start_pc;
          illegal     <= 1'b0;
          instr_count <= '0;
        end
        S_FETCH: imem_addr <= pc;
        S_DECODE: begin
          ir  <= imem_rdata;
          bud <= dec_budget;
          if (!dec_halt && !dec_legal) begin
            illegal <= 1'b1;
            pc      <= pc + 1'b1;
          end
        end
        S_LOAD:  ctrl_instruction <= ir;
        S_START: cnt <= bud - 16'd1;
        S_RUN: begin
          if (cnt == 16'd0) begin
            pc <= pc + 1'b1;
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: single-instruction table plus hand-written
// multi-cycle sequences (multi-instruction, illegal skip, abort, wrap, async reset).
module tb_instr_sequencer;
  import pim_pkg::*;

  logic        clk = 1'b0;
  logic        reset, go, abort;
  logic [7:0]  start_pc, imem_addr, pc;
  logic [31:0] imem_rdata, ctrl_instruction;
  logic        ctrl_reset, ctrl_start, busy, done, illegal;
  logic [15:0] instr_count;

  logic [31:0] rom [256];
  int checks = 0;
  int failures = 0;

  int          starts, prelow_bad, unstable, cur_run;
  int          run_lens[$];
  bit          prev_cr, saw4;
  logic [31:0] run_instr;

  int lat, rc, got_run;
  bit hit;

  typedef struct {
    logic [5:0] op;
    int         lat;
    int         starts;
    int         run;
    int         cnt;
    bit         ill;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  instr_sequencer #(.LENGTH(32), .IMEM_AW(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .go               (go),
    .abort            (abort),
    .start_pc         (start_pc),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .ctrl_reset       (ctrl_reset),
    .ctrl_start       (ctrl_start),
    .ctrl_instruction (ctrl_instruction),
    .busy             (busy),
    .done             (done),
    .illegal          (illegal),
    .pc               (pc),
    .instr_count      (instr_count)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'h0611000};
  endfunction

  task automatic rom_fill();
    for (int i = 0; i < 256; i++) rom[i] = mk(OP_HALT);
  endtask

  task automatic mon_clear();
    starts = 0; prelow_bad = 0; unstable = 0; cur_run = 0;
    run_lens.delete();
    prev_cr = 1'b0; saw4 = 1'b0; run_instr = '0;
  endtask

  task automatic mon_sample();
    if (ctrl_start) begin
      starts++;
      if (prev_cr) prelow_bad++;
      run_instr = ctrl_instruction;
      cur_run = 0;
    end else if (ctrl_reset) begin
      cur_run++;
      if (ctrl_instruction != run_instr) unstable++;
    end else if (cur_run > 0) begin
      run_lens.push_back(cur_run);
      cur_run = 0;
    end
    if (ctrl_instruction[31:26] == 6'd4) saw4 = 1'b1;
    prev_cr = ctrl_reset;
  endtask

  // lat = cycles from the FETCH state to the first DONE cycle, -1 on timeout
  task automatic run_prog(input logic [7:0] spc, input int maxcyc, input int go_at, output int l);
    @(negedge clk);
    start_pc = spc;
    go = 1'b1;
    l = -1;
    for (int k = 0; k < maxcyc; k++) begin
      @(negedge clk);
      go = (k == go_at);
      if (k == go_at) start_pc = spc + 8'd7;
      mon_sample();
      if (done) begin
        l = k;
        break;
      end
    end
    go = 1'b0;
  endtask

  initial begin
    go = 1'b0; abort = 1'b0; start_pc = '0;
    rom_fill();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ctrl_reset", ctrl_reset, 0);
    chk("rst_outputs", {ctrl_start, illegal, pc, imem_addr, ctrl_instruction, instr_count}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    tbl[0] = '{OP_ADD,   74,   1, 66,   1, 1'b0};
    tbl[1] = '{OP_SUB,   74,   1, 66,   1, 1'b0};
    tbl[2] = '{6'd3,     6,    0, 0,    0, 1'b1};
    tbl[3] = '{OP_RADD,  74,   1, 66,   1, 1'b0};
    tbl[4] = '{OP_EAST,  43,   1, 35,   1, 1'b0};
    tbl[5] = '{6'd62,    6,    0, 0,    0, 1'b1};
    tbl[6] = '{OP_NORTH, 43,   1, 35,   1, 1'b0};
    tbl[7] = '{OP_RSUB,  74,   1, 66,   1, 1'b0};
    tbl[8] = '{OP_MUL,   2287, 1, 2279, 1, 1'b0};

    for (int i = 0; i < 9; i++) begin
      rom_fill();
      rom[0] = mk(tbl[i].op);
      mon_clear();
      run_prog(8'd0, 3000, -1, lat);
      got_run = (run_lens.size() > 0) ? run_lens[0] : 0;
      chk($sformatf("t%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("t%0d_starts", i), starts, tbl[i].starts);
      chk($sformatf("t%0d_run_len", i), got_run, tbl[i].run);
      chk($sformatf("t%0d_count", i), instr_count, tbl[i].cnt);
      chk($sformatf("t%0d_illegal", i), illegal, tbl[i].ill);
      chk($sformatf("t%0d_pc", i), pc, 1);
      chk($sformatf("t%0d_unstable", i), unstable, 0);
    end

    // MUL; EAST; HALT with a go pulse ignored mid-run
    rom_fill();
    rom[0] = mk(OP_MUL); rom[1] = mk(OP_EAST);
    mon_clear();
    run_prog(8'd0, 3000, 100, lat);
    chk("me_latency", lat, 2327);
    chk("me_starts", starts, 2);
    chk("me_runs", run_lens.size(), 2);
    chk("me_run0", (run_lens.size() > 0) ? run_lens[0] : 0, 2279);
    chk("me_run1", (run_lens.size() > 1) ? run_lens[1] : 0, 35);
    chk("me_prelow", prelow_bad, 0);
    chk("me_unstable", unstable, 0);
    chk("me_count", instr_count, 2);
    chk("me_pc", pc, 2);

    // illegal opcode 4 is skipped, never issued
    rom_fill();
    rom[0] = mk(6'd4); rom[1] = mk(OP_ADD);
    mon_clear();
    run_prog(8'd0, 300, -1, lat);
    chk("il_latency", lat, 77);
    chk("il_illegal", illegal, 1);
    chk("il_saw_op4", saw4, 0);
    chk("il_count", instr_count, 1);
    chk("il_pc", pc, 2);

    // pc wraps from 255 to 0
    rom_fill();
    rom[255] = mk(OP_ADD);
    mon_clear();
    run_prog(8'd255, 300, -1, lat);
    chk("wr_latency", lat, 74);
    chk("wr_pc", pc, 0);
    chk("wr_done", done, 1);
    chk("wr_count", instr_count, 1);

    // abort on RUN cycle 10 of the second ADD
    rom_fill();
    rom[2] = mk(OP_ADD); rom[3] = mk(OP_ADD);
    rc = 0; hit = 1'b0;
    @(negedge clk);
    start_pc = 8'd2; go = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      go = 1'b0;
      if (ctrl_reset && !ctrl_start) rc++;
      if (rc == 76) begin
        hit = 1'b1;
        break;
      end
    end
    chk("ab_reached", hit, 1);
    abort = 1'b1; go = 1'b1;
    @(negedge clk);
    abort = 1'b0; go = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_ctrl_reset", ctrl_reset, 0);
    chk("ab_ctrl_start", ctrl_start, 0);
    chk("ab_done", done, 0);
    chk("ab_pc_held", pc, 3);
    chk("ab_count_held", instr_count, 1);
    @(negedge clk);
    chk("ab_stays_idle", busy, 0);
    mon_clear();
    run_prog(8'd2, 400, -1, lat);
    chk("ab_restart_latency", lat, 145);
    chk("ab_restart_count", instr_count, 2);
    chk("ab_restart_pc", pc, 4);

    // async reset mid-RUN
    rom_fill();
    rom[5] = mk(OP_ADD);
    rc = 0; hit = 1'b0;
    @(negedge clk);
    start_pc = 8'd5; go = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      go = 1'b0;
      if (ctrl_reset && !ctrl_start) rc++;
      if (rc == 20) begin
        hit = 1'b1;
        break;
      end
    end
    chk("ar_reached", hit, 1);
    #2 reset = 1'b0; go = 1'b1;
    #1;
    chk("ar_ctrl_reset", ctrl_reset, 0);
    chk("ar_busy", busy, 0);
    chk("ar_outputs", {ctrl_start, done, illegal, pc, imem_addr, ctrl_instruction, instr_count}, 0);
    repeat (3) @(negedge clk);
    chk("ar_go_ignored", {busy, pc}, 0);
    go = 1'b0;
    reset = 1'b1;
    mon_clear();
    run_prog(8'd5, 300, -1, lat);
    chk("ar_after_latency", lat, 74);
    chk("ar_after_pc", pc, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
